// File: rtl/pc_fetch_unit_pkg.sv
// ============================================================================
// Module   : pc_fetch_unit_pkg
// Brief    : Shared word width, reset defaults and FSM encoding for the fetch unit
// Revision : 1.0
// ============================================================================
`default_nettype none

package pc_fetch_unit_pkg;

    localparam int unsigned c_WORD_W = 32;

    localparam logic [c_WORD_W-1:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [c_WORD_W-1:0] c_PC_STEP  = 32'd4;

    localparam logic [2:0] c_ST_FETCH = 3'd0;
    localparam logic [2:0] c_ST_WAIT  = 3'd1;
    localparam logic [2:0] c_ST_EXEC  = 3'd2;
    localparam logic [2:0] c_ST_HALT  = 3'd3;
    localparam logic [2:0] c_ST_ERR   = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH = c_ST_FETCH,
        ST_WAIT  = c_ST_WAIT,
        ST_EXEC  = c_ST_EXEC,
        ST_HALT  = c_ST_HALT,
        ST_ERR   = c_ST_ERR
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_fetch_watchdog.sv
// ============================================================================
// Module   : fetch_watchdog
// Brief    : Counts consecutive un-acked wait cycles and flags the timeout cycle
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_clr,
    input  logic in_en,
    output logic out_expired
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] w_cnt_inc;

    assign w_cnt_inc   = cnt_q + 16'd1;
    // Expiry is flagged in the cycle whose increment reaches the limit.
    assign out_expired = in_en && (w_cnt_inc == 16'(TIMEOUT_CYC));

    always_comb begin
        cnt_d = cnt_q;
        if (in_clr) begin
            cnt_d = '0;
        end else if (in_en && !out_expired) begin
            cnt_d = w_cnt_inc;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : PC register and req/ack instruction-fetch sequencer with halt/stall
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = c_RESET_PC,
    parameter logic [31:0] PC_STEP     = c_PC_STEP,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [31:0]      in_pcin,
    input  logic             in_halt,
    input  logic             in_go,
    input  logic             in_stall,
    output logic             out_imem_req,
    output logic [31:0]      out_imem_addr,
    input  logic             in_imem_ack,
    input  logic [31:0]      in_imem_data,
    output logic [31:0]      out_pcout,
    output logic [31:0]      out_pcc,
    output logic [31:0]      out_is,
    output logic             out_valid,
    output logic             out_halted,
    output logic             out_fetch_err,
    output logic [CNT_W-1:0] out_icount
);

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        is_q, is_d;
    logic [CNT_W-1:0]   icount_q, icount_d;

    logic w_wd_clr;
    logic w_wd_en;
    logic w_wd_expired;
    logic w_req;
    logic w_valid;
    logic w_halted;
    logic w_err;

    fetch_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_clr      (w_wd_clr),
        .in_en       (w_wd_en),
        .out_expired (w_wd_expired)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        is_d     = is_q;
        icount_d = icount_q;
        w_wd_clr = 1'b0;
        w_wd_en  = 1'b0;
        w_req    = 1'b0;
        w_valid  = 1'b0;
        w_halted = 1'b0;
        w_err    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                w_req    = 1'b1;
                w_wd_clr = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                w_req = 1'b1;
                // An ack arriving on the timeout cycle still completes the fetch.
                if (in_imem_ack) begin
                    is_d    = in_imem_data;
                    state_d = ST_EXEC;
                end else begin
                    w_wd_en = 1'b1;
                    if (w_wd_expired) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_EXEC: begin
                w_valid = 1'b1;
                if (!in_stall) begin
                    pc_d = in_pcin;
                    if (icount_q != {CNT_W{1'b1}}) begin
                        icount_d = icount_q + CNT_W'(1);
                    end
                    state_d = in_halt ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                w_halted = 1'b1;
                if (in_go) begin
                    state_d = ST_FETCH;
                end
            end
            ST_ERR: begin
                w_err = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            is_q     <= '0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            is_q     <= is_d;
            icount_q <= icount_d;
        end
    end

    // Strobes are masked by reset so a pending request drops while reset is held.
    assign out_imem_req  = w_req    & ~in_rst;
    assign out_valid     = w_valid  & ~in_rst;
    assign out_halted    = w_halted & ~in_rst;
    assign out_fetch_err = w_err    & ~in_rst;

    assign out_imem_addr = pc_q;
    assign out_pcout     = pc_q;
    assign out_pcc       = pc_q + PC_STEP;
    assign out_is        = is_q;
    assign out_icount    = icount_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Scoreboard bench for pc_fetch_unit with directed fetch/exec vectors
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      in_pcin = '0;
    logic             in_halt = 1'b0;
    logic             in_go = 1'b0;
    logic             in_stall = 1'b0;
    logic             in_imem_ack = 1'b0;
    logic [31:0]      in_imem_data = '0;
    logic             out_imem_req;
    logic [31:0]      out_imem_addr;
    logic [31:0]      out_pcout;
    logic [31:0]      out_pcc;
    logic [31:0]      out_is;
    logic             out_valid;
    logic             out_halted;
    logic             out_fetch_err;
    logic [CNT_W-1:0] out_icount;

    pc_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .PC_STEP     (32'd4),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (4)
    ) dut (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_pcin       (in_pcin),
        .in_halt       (in_halt),
        .in_go         (in_go),
        .in_stall      (in_stall),
        .out_imem_req  (out_imem_req),
        .out_imem_addr (out_imem_addr),
        .in_imem_ack   (in_imem_ack),
        .in_imem_data  (in_imem_data),
        .out_pcout     (out_pcout),
        .out_pcc       (out_pcc),
        .out_is        (out_is),
        .out_valid     (out_valid),
        .out_halted    (out_halted),
        .out_fetch_err (out_fetch_err),
        .out_icount    (out_icount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcc;
        logic [31:0] is;
        logic [3:0]  icnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_e;
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [3:0]  exp_icnt = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid execute cycle must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid with pc %h expected no valid", out_pcout);
            end else begin
                mon_e = sb.pop_front();
                chk("exec_pc",     out_pcout, mon_e.pc);
                chk("exec_pcc",    out_pcc,   mon_e.pcc);
                chk("exec_is",     out_is,    mon_e.is);
                chk("exec_icount", 32'(out_icount), 32'(mon_e.icnt));
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (out_imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (out_imem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got req %b expected 1 within 20 cycles", out_imem_req);
        end
    endtask

    task automatic fetch(input logic [31:0] data, input int delay);
        wait_req();
        chk("fetch_addr", out_imem_addr, exp_pc);
        repeat (delay) @(negedge clk);
        chk("wait_req", 32'(out_imem_req), 32'd1);
        chk("wait_addr", out_imem_addr, exp_pc);
        last_e = '{exp_pc, exp_pc + 32'd4, data, exp_icnt};
        sb.push_back(last_e);
        in_imem_ack  = 1'b1;
        in_imem_data = data;
        @(negedge clk);
        in_imem_ack  = 1'b0;
        in_imem_data = 32'hDEAD_BEEF;
    endtask

    task automatic exec(input logic [31:0] pcin, input logic halt, input int stalls);
        for (int i = 0; i < stalls; i++) begin
            in_stall = 1'b1;
            in_halt  = halt;
            in_pcin  = 32'hBAD0_0000;
            sb.push_back(last_e);
            @(negedge clk);
        end
        in_stall = 1'b0;
        in_halt  = halt;
        in_pcin  = pcin;
        @(negedge clk);
        in_halt  = 1'b0;
        exp_pc   = pcin;
        if (exp_icnt != 4'hF) exp_icnt = exp_icnt + 4'h1;
        chk("post_icount", 32'(out_icount), 32'(exp_icnt));
        chk("post_pc", out_pcout, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        // Reset state
        in_imem_ack = 1'b1;
        @(negedge clk);
        chk("rst_req",    32'(out_imem_req),  32'd0);
        chk("rst_valid",  32'(out_valid),     32'd0);
        chk("rst_halted", 32'(out_halted),    32'd0);
        chk("rst_err",    32'(out_fetch_err), 32'd0);
        chk("rst_pc",     out_pcout,          32'h0);
        chk("rst_pcc",    out_pcc,            32'h4);
        chk("rst_is",     out_is,             32'h0);
        chk("rst_icount", 32'(out_icount),    32'd0);
        in_imem_ack = 1'b0;
        rst = 1'b0;

        // 1/2: first fetch, ack two cycles after request, then jump to 0x40
        fetch(32'h1234_5678, 2);
        chk("t1_is",  out_is,  32'h1234_5678);
        chk("t1_pcc", out_pcc, 32'h4);
        exec(32'h0000_0040, 1'b0, 0);
        wait_req();
        chk("t2_addr", out_imem_addr, 32'h40);
        chk("t2_icount", 32'(out_icount), 32'd1);

        // 3: stall beats halt, then halt and resume
        fetch(32'hCAFE_0001, 1);
        exec(32'h0000_0080, 1'b1, 3);
        chk("t3_halted", 32'(out_halted), 32'd1);
        chk("t3_req",    32'(out_imem_req), 32'd0);
        in_imem_ack = 1'b1;
        @(negedge clk);
        in_imem_ack = 1'b0;
        chk("t3_still_halted", 32'(out_halted), 32'd1);
        chk("t3_pc", out_pcout, 32'h80);
        in_go = 1'b1;
        @(negedge clk);
        in_go = 1'b0;
        chk("t3_resume_addr", out_imem_addr, 32'h80);

        // 5: PC wrap and counter saturation
        fetch(32'hCAFE_0002, 4);
        exec(32'hFFFF_FFFC, 1'b0, 0);
        fetch(32'hCAFE_0003, 1);
        chk("t5_pcc_wrap", out_pcc, 32'h0);
        exec(32'h0000_0100, 1'b0, 0);
        for (int i = 0; i < 13; i++) begin
            fetch(32'hA000_0000 + 32'(i), 1);
            exec(32'h0000_0104 + 32'(i * 4), 1'b0, 0);
        end
        chk("t5_sat", 32'(out_icount), 32'hF);

        // 4: watchdog timeout
        wait_req();
        chk("t4_addr", out_imem_addr, exp_pc);
        repeat (4) begin
            @(negedge clk);
            chk("t4_wait_err", 32'(out_fetch_err), 32'd0);
            chk("t4_wait_req", 32'(out_imem_req),  32'd1);
        end
        @(negedge clk);
        chk("t4_err", 32'(out_fetch_err), 32'd1);
        chk("t4_req", 32'(out_imem_req),  32'd0);
        in_imem_ack  = 1'b1;
        in_imem_data = 32'h5555_AAAA;
        repeat (2) @(negedge clk);
        in_imem_ack  = 1'b0;
        chk("t4_err_sticky", 32'(out_fetch_err), 32'd1);
        chk("t4_pc_frozen",  out_pcout, exp_pc);
        chk("t4_is_kept",    out_is,    32'hA000_000C);
        rst = 1'b1;
        #1;
        chk("t4_rst_err", 32'(out_fetch_err), 32'd0);
        chk("t4_rst_pc",  out_pcout,          32'h0);
        @(negedge clk);
        rst      = 1'b0;
        exp_pc   = 32'h0;
        exp_icnt = 4'h0;

        // 6: reset in the middle of a wait
        fetch(32'h0BAD_F00D, 1);
        exec(32'h0000_0020, 1'b0, 0);
        wait_req();
        chk("t6_addr", out_imem_addr, 32'h20);
        @(negedge clk);
        chk("t6_wait_req", 32'(out_imem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_req_drop", 32'(out_imem_req), 32'd0);
        chk("t6_pc",       out_pcout,         32'h0);
        @(negedge clk);
        rst      = 1'b0;
        exp_pc   = 32'h0;
        exp_icnt = 4'h0;
        fetch(32'h7777_0000, 3);
        exec(32'h0000_0008, 1'b0, 0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
